// File: rtl/ram_responder.sv
// RAM-side responder for cpu_ram_if: word read/write with LAT-cycle latency and FREE/BUSY/ACCESS/ERROR status.
// Optional feature: define RAM_ALIGN_CHECK_EN to flag misaligned byte addresses as ERROR.
module ram_responder #(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] memaddr,
   input  logic [31:0] memstore,
   input  logic        memREN,
   input  logic        memWEN,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0]  RS_FREE   = 2'd0;
   localparam logic [1:0]  RS_BUSY   = 2'd1;
   localparam logic [1:0]  RS_ACCESS = 2'd2;
   localparam logic [1:0]  RS_ERROR  = 2'd3;
   localparam logic [3:0]  LAT_M1    = 4'(LAT - 1);
   localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
   localparam state_t      FIRST_ST  = (LAT == 1) ? ST_DONE : ST_WAIT;

   state_t        state_r, state_nxt_s;
   logic [3:0]    cnt_r, cnt_nxt_s;
   logic [31:0]   addr_r, addr_nxt_s;
   logic          op_r, op_nxt_s;
   logic [31:0]   held_r;
   logic [31:0]   mem_r [DEPTH];

   logic          req_s, bad_s, range_bad_s, align_bad_s, change_s, access_s;
   logic [AW-1:0] idx_s;

   // Request decode and error classification.
   always_comb begin
      req_s       = memREN ^ memWEN;
      range_bad_s = (memaddr[31:2] >= DEPTH_W);
`ifdef RAM_ALIGN_CHECK_EN
      align_bad_s = (memaddr[1:0] != 2'd0);
`else
      align_bad_s = 1'b0;
`endif
      bad_s       = (memREN & memWEN) | range_bad_s | align_bad_s;
      change_s    = !req_s || (memaddr != addr_r) || (memWEN != op_r);
      idx_s       = addr_r[AW+1:2];
      access_s    = (state_r == ST_DONE) && !bad_s;
   end

   // Status output, ERROR taking priority over everything.
   always_comb begin
      ramstate = RS_FREE;
      if (bad_s) begin
         ramstate = RS_ERROR;
      end else if (state_r == ST_DONE) begin
         ramstate = RS_ACCESS;
      end else if (((state_r == ST_IDLE) && req_s) || (state_r == ST_WAIT)) begin
         ramstate = RS_BUSY;
      end else begin
         ramstate = RS_FREE;
      end
   end

   // Read data: live memory word during a read ACCESS, otherwise the last value read.
   always_comb begin
      ramload = held_r;
      if (access_s && !op_r) begin
         ramload = mem_r[idx_s];
      end else begin
         ramload = held_r;
      end
   end

   // Next-state logic: latch, count latency, abort on request change or error.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      addr_nxt_s  = addr_r;
      op_nxt_s    = op_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s && !bad_s) begin
               addr_nxt_s  = memaddr;
               op_nxt_s    = memWEN;
               cnt_nxt_s   = 4'd1;
               state_nxt_s = FIRST_ST;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (bad_s) begin
               state_nxt_s = ST_IDLE;
            end else if (change_s) begin
               // A different valid request restarts the latency count from scratch.
               if (req_s) begin
                  addr_nxt_s  = memaddr;
                  op_nxt_s    = memWEN;
                  cnt_nxt_s   = 4'd1;
                  state_nxt_s = FIRST_ST;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else if (cnt_r == LAT_M1) begin
               state_nxt_s = ST_DONE;
            end else begin
               cnt_nxt_s   = cnt_r + 4'd1;
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         addr_r  <= 32'd0;
         op_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         addr_r  <= addr_nxt_s;
         op_r    <= op_nxt_s;
      end
   end

   // Memory array and held read-data register; write data is sampled on the ACCESS edge.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'd0;
         end
         held_r <= 32'd0;
      end else if (access_s && op_r) begin
         mem_r[idx_s] <= memstore;
      end else if (access_s && !op_r) begin
         held_r <= mem_r[idx_s];
      end
   end

endmodule
